// File: rtl/alu_control_unit_pkg.sv
// Shared types and constants for the ALU control unit: FSM states,
// the LOAD-immediate opcode and default sizing.
package alu_control_unit_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    EXEC  = 2'd2,
    WRITE = 2'd3
  } state_t;

  localparam logic [2:0] OP_LOAD          = 3'b111;
  localparam int         DEFAULT_DATA_W   = 4;
  localparam int         DEFAULT_NUM_REGS = 4;

endpackage

// File: rtl/alu_control_unit_reg_file.sv
// Register file: one synchronous write port, two combinational operand read
// ports and one combinational debug read port, cleared synchronously on reset.
module reg_file_4x4
  import alu_control_unit_pkg::*;
#(
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int NUM_REGS = DEFAULT_NUM_REGS,
  parameter int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2,
  input  logic [ADDR_W-1:0] dbg_raddr,
  output logic [DATA_W-1:0] dbg_rdata
);

  logic [DATA_W-1:0] mem [NUM_REGS];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata1    = mem[raddr1];
  assign rdata2    = mem[raddr2];
  assign dbg_rdata = mem[dbg_raddr];

endmodule

// File: rtl/alu_control_unit.sv
// Four-phase instruction controller: fetches operands from the register file,
// drives an external combinational ALU and writes the result back.
module alu_control_unit
  import alu_control_unit_pkg::*;
#(
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int NUM_REGS = DEFAULT_NUM_REGS,
  parameter int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [2:0]        instr_opcode,
  input  logic [ADDR_W-1:0] instr_rd,
  input  logic [ADDR_W-1:0] instr_rs1,
  input  logic [ADDR_W-1:0] instr_rs2,
  output logic [DATA_W-1:0] alu_opperand_1,
  output logic [DATA_W-1:0] alu_opperand_2,
  output logic [2:0]        alu_opcode,
  input  logic [DATA_W-1:0] alu_result,
  output logic              wb_valid,
  output logic [ADDR_W-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output state_t            dbg_state
);

  // Handshake: an instruction transfers on a rising edge where instr_valid and
  // instr_ready are both 1; instr_ready is 1 only in IDLE, and a held
  // instr_valid simply waits until IDLE comes round again.

  state_t            state;
  logic [2:0]        op_q;
  logic [ADDR_W-1:0] rd_q, rs1_q, rs2_q;
  logic [DATA_W-1:0] result_q;
  logic [DATA_W-1:0] rdata1, rdata2;
  logic [DATA_W-1:0] imm;
  logic              is_load;

  assign instr_ready = (state == IDLE);
  assign dbg_state   = state;
  assign is_load     = (op_q == OP_LOAD);
  // LOAD carries its immediate in the two source-register fields.
  assign imm         = DATA_W'({rs1_q, rs2_q});

  reg_file_4x4 #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) u_reg_file (
    .clk       (clk),
    .rst_n     (rst_n),
    .we        (state == WRITE),
    .waddr     (rd_q),
    .wdata     (result_q),
    .raddr1    (rs1_q),
    .rdata1    (rdata1),
    .raddr2    (rs2_q),
    .rdata2    (rdata2),
    .dbg_raddr (dbg_addr),
    .dbg_rdata (dbg_data)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      op_q           <= 3'b000;
      rd_q           <= '0;
      rs1_q          <= '0;
      rs2_q          <= '0;
      result_q       <= '0;
      alu_opperand_1 <= '0;
      alu_opperand_2 <= '0;
      alu_opcode     <= 3'b000;
      wb_valid       <= 1'b0;
      wb_addr        <= '0;
      wb_data        <= '0;
    end else begin
      wb_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (instr_valid) begin
            op_q  <= instr_opcode;
            rd_q  <= instr_rd;
            rs1_q <= instr_rs1;
            rs2_q <= instr_rs2;
            state <= READ;
          end
        end
        READ: begin
          // ALU outputs only move for real ALU ops so its inputs stay stable.
          if (!is_load) begin
            alu_opperand_1 <= rdata1;
            alu_opperand_2 <= rdata2;
            alu_opcode     <= op_q;
          end
          state <= EXEC;
        end
        EXEC: begin
          result_q <= is_load ? imm : alu_result;
          state    <= WRITE;
        end
        WRITE: begin
          wb_valid <= 1'b1;
          wb_addr  <= rd_q;
          wb_data  <= result_q;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
